// File: rtl/lfsr_rand_fifo.sv
// Decimating sampler of LFSR state into a small FWFT FIFO with overflow count and lockup flag.
// One-cycle capture-to-output; captures arriving while full (and not popping) are dropped and counted.
module lfsr_rand_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int DECIM = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic [WIDTH-1:0]           lfsr_state_i,
    output logic [WIDTH-1:0]           rand_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [15:0]                drop_cnt_o,
    output logic                       stuck_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]       dcnt_q, dcnt_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             stuck_q, stuck_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic capture, pop, push, drop, full;

    assign full    = (count_q == CW'(DEPTH));
    assign capture = enable_i && (dcnt_q == 8'(DECIM - 1));
    assign pop     = valid_o && ready_i;
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        dcnt_d     = dcnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        stuck_d    = stuck_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;

        if (enable_i) begin
            dcnt_d = (dcnt_q == 8'(DECIM - 1)) ? 8'd0 : dcnt_q + 8'd1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        // Lockup check sees every capture, including dropped ones.
        if (capture) begin
            if (lfsr_state_i == '0 || (prev_vld_q && lfsr_state_i == prev_q)) begin
                stuck_d = 1'b1;
            end
            prev_d     = lfsr_state_i;
            prev_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dcnt_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            stuck_q    <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            dcnt_q     <= dcnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            stuck_q    <= stuck_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            if (push) begin
                mem_q[wr_ptr_q] <= lfsr_state_i;
            end
        end
    end

    assign rand_o     = mem_q[rd_ptr_q];
    assign valid_o    = (count_q != '0);
    assign count_o    = count_q;
    assign drop_cnt_o = drop_cnt_q;
    assign stuck_o    = stuck_q;
endmodule

// File: tb/tb_lfsr_rand_fifo.sv
// Directed bench for lfsr_rand_fifo: one instance with DECIM=1, one with DECIM=3.
module tb_lfsr_rand_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        en1 = 1'b0, rdy1 = 1'b0;
    logic [31:0] st1 = '0;
    logic [31:0] rand1;
    logic        vld1, stuck1;
    logic [2:0]  cnt1;
    logic [15:0] drop1;

    logic        en3 = 1'b0, rdy3 = 1'b0;
    logic [31:0] st3 = '0;
    logic [31:0] rand3;
    logic        vld3, stuck3;
    logic [2:0]  cnt3;
    logic [15:0] drop3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_rand_fifo #(.WIDTH(32), .DEPTH(4), .DECIM(1)) u_d1 (
        .clk(clk), .reset(reset), .enable_i(en1), .lfsr_state_i(st1),
        .rand_o(rand1), .valid_o(vld1), .ready_i(rdy1), .count_o(cnt1),
        .drop_cnt_o(drop1), .stuck_o(stuck1)
    );

    lfsr_rand_fifo #(.WIDTH(32), .DEPTH(4), .DECIM(3)) u_d3 (
        .clk(clk), .reset(reset), .enable_i(en3), .lfsr_state_i(st3),
        .rand_o(rand3), .valid_o(vld3), .ready_i(rdy3), .count_o(cnt3),
        .drop_cnt_o(drop3), .stuck_o(stuck3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses reset between clock edges.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        tick();
        check("reset_valid", {31'b0, vld1}, 32'd0);
        check("reset_count", {29'b0, cnt1}, 32'd0);
        check("reset_drop", {16'b0, drop1}, 32'd0);
        check("reset_stuck", {31'b0, stuck1}, 32'd0);
        check("reset_rand", rand1, 32'd0);

        // Single sample round trip
        rdy1 = 1'b1; en1 = 1'b1; st1 = 32'h5;
        tick();
        check("t1_valid", {31'b0, vld1}, 32'd1);
        check("t1_rand", rand1, 32'h5);
        check("t1_count", {29'b0, cnt1}, 32'd1);
        en1 = 1'b0;
        tick();
        check("t1_valid_after", {31'b0, vld1}, 32'd0);
        check("t1_count_after", {29'b0, cnt1}, 32'd0);
        check("t1_stuck", {31'b0, stuck1}, 32'd0);

        // Overflow: six captures into four entries
        do_reset();
        rdy1 = 1'b0; en1 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            st1 = i;
            tick();
        end
        check("t2_count", {29'b0, cnt1}, 32'd4);
        check("t2_drop", {16'b0, drop1}, 32'd2);
        en1 = 1'b0; rdy1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t2_rand_seq", rand1, i);
            check("t2_valid_seq", {31'b0, vld1}, 32'd1);
            tick();
        end
        check("t2_valid_empty", {31'b0, vld1}, 32'd0);

        // Push and pop together on a full FIFO
        do_reset();
        rdy1 = 1'b0; en1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            st1 = i;
            tick();
        end
        check("t3_full", {29'b0, cnt1}, 32'd4);
        rdy1 = 1'b1; st1 = 32'h9;
        tick();
        check("t3_count", {29'b0, cnt1}, 32'd4);
        check("t3_drop", {16'b0, drop1}, 32'd0);
        en1 = 1'b0;
        check("t3_head2", rand1, 32'd2);
        tick();
        check("t3_head3", rand1, 32'd3);
        tick();
        check("t3_head4", rand1, 32'd4);
        tick();
        check("t3_head9", rand1, 32'd9);
        tick();
        check("t3_empty", {31'b0, vld1}, 32'd0);

        // Decimation by 3 with an enable gap
        do_reset();
        rdy3 = 1'b1; en3 = 1'b1;
        for (int k = 10; k <= 18; k++) begin
            st3 = k;
            tick();
            check("t4_valid", {31'b0, vld3}, (k % 3 == 0) ? 32'd1 : 32'd0);
            if (k % 3 == 0) check("t4_rand", rand3, k);
        end
        st3 = 19;
        tick();
        check("t4_v19", {31'b0, vld3}, 32'd0);
        en3 = 1'b0;
        st3 = 20;
        tick();
        st3 = 21;
        tick();
        check("t4_v21_gap", {31'b0, vld3}, 32'd0);
        en3 = 1'b1;
        st3 = 22;
        tick();
        check("t4_v22", {31'b0, vld3}, 32'd0);
        st3 = 23;
        tick();
        check("t4_v23", {31'b0, vld3}, 32'd1);
        check("t4_r23", rand3, 32'd23);
        en3 = 1'b0;

        // Lockup: repeated sample, then all-zero sample
        do_reset();
        rdy1 = 1'b1; en1 = 1'b1; st1 = 32'h7;
        tick();
        check("t5_stuck_first7", {31'b0, stuck1}, 32'd0);
        tick();
        check("t5_stuck_repeat", {31'b0, stuck1}, 32'd1);
        en1 = 1'b0;
        do_reset();
        check("t5_stuck_cleared", {31'b0, stuck1}, 32'd0);
        en1 = 1'b1; st1 = 32'h0;
        tick();
        check("t5_stuck_zero", {31'b0, stuck1}, 32'd1);
        en1 = 1'b0; st1 = 32'h1;
        tick();
        tick();
        check("t5_stuck_sticky", {31'b0, stuck1}, 32'd1);

        // Asynchronous reset mid-operation
        do_reset();
        rdy1 = 1'b0; en1 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            st1 = 32'h100 + i;
            tick();
        end
        en1 = 1'b0; rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
        check("t6_pre_count", {29'b0, cnt1}, 32'd3);
        check("t6_pre_drop", {16'b0, drop1}, 32'd5);
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid", {31'b0, vld1}, 32'd0);
        check("t6_count", {29'b0, cnt1}, 32'd0);
        check("t6_drop", {16'b0, drop1}, 32'd0);
        check("t6_stuck", {31'b0, stuck1}, 32'd0);
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_rand_fifo.md
Name: lfsr_rand_fifo

Overview:
Downstream consumer of the 32-bit LFSR state output. It decimates the free-running LFSR state and captures one sample every DECIM enabled cycles. Samples are buffered in a small first-word-fall-through FIFO and handed to consumers over a valid/ready interface. The block also counts samples lost to overflow and flags a locked-up LFSR (all-zero or repeated state).

Parameters:
WIDTH, 32, sample width; matches the LFSR state width.
DEPTH, 4, FIFO entries; power of two, >=2.
DECIM, 1, capture one sample every DECIM enabled cycles; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
enable_i  input  1  sampling enable; gates the decimation counter and captures.
lfsr_state_i  input  WIDTH  current LFSR state, sampled on the clk edge.
rand_o  output  WIDTH  FIFO head word; meaningful only while valid_o=1.
valid_o  output  1  FIFO non-empty.
ready_i  input  1  consumer accepts rand_o when valid_o && ready_i at the clk edge.
count_o  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
drop_cnt_o  output  16  number of captures discarded because the FIFO was full; saturating.
stuck_o  output  1  sticky LFSR-lockup flag.

Behaviour:
- Reset (reset=0, asynchronous): decimation counter=0, rd/wr pointers=0, count_o=0, valid_o=0, rand_o=0, drop_cnt_o=0, stuck_o=0, prev-sample-valid=0. Memory contents are don't-care.
- Decimation counter dcnt:
  - When enable_i=1, dcnt counts 0..DECIM-1 and wraps to 0.
  - When enable_i=0, dcnt holds and no capture occurs.
  - capture = enable_i && (dcnt==DECIM-1). For DECIM=1, every enabled cycle is a capture.
- pop = valid_o && ready_i.
- push = capture && (count_o<DEPTH || pop). A push writes lfsr_state_i at mem[wr_ptr], sampled on the same edge.
- drop = capture && count_o==DEPTH && !pop. On a drop, drop_cnt_o += 1, saturating at 16'hFFFF.
- Occupancy: count_o += push - pop. Pointers wrap modulo DEPTH.
- Latency: a sample captured at edge t appears on rand_o/valid_o immediately after edge t (one-cycle capture-to-output).
- FWFT behaviour: rand_o always shows mem[rd_ptr]. valid_o = (count_o!=0), registered, with no combinational path from ready_i.
- Simultaneous push and pop:
  - When full, both are accepted and count is unchanged; no drop.
  - When empty, pop is impossible (valid_o=0), so only the push takes effect.
- ready_i while valid_o=0 is ignored.
- Lockup detection, evaluated on every capture (pushed or dropped):
  - stuck_o is set if the sample is all-zero, or if prev-sample-valid=1 and the sample equals the previous captured sample.
  - The previous sample register and prev-sample-valid=1 update on every capture.
  - stuck_o clears only on reset.
- Reset mid-operation: all state returns to reset values immediately. A word on rand_o is lost and no pop is counted.
- Deassertion of reset is synchronised externally; the first capture can occur at the first clk edge with reset=1.

Test Plan:
1. DECIM=1, DEPTH=4, ready_i=1; one enabled cycle with lfsr_state_i=32'h00000005 -> next cycle valid_o=1, rand_o=5, count_o=1; the following cycle valid_o=0, count_o=0, stuck_o=0.
2. ready_i=0, enable_i=1 for 6 cycles with states 1..6 -> FIFO holds 1,2,3,4, count_o=4, drop_cnt_o=2. Then ready_i=1, enable_i=0 -> rand_o sequence 1,2,3,4, after which valid_o=0.
3. Full FIFO (1..4), ready_i=1 and a capture of 9 in the same cycle -> no drop; contents become 2,3,4,9, count_o stays 4, drop_cnt_o unchanged.
4. DECIM=3, enable_i=1 continuously, state = cycle index 10,11,12,... -> captures 12,15,18. Dropping enable_i for 2 cycles mid-count delays the next capture by exactly 2 cycles.
5. Captures 7 then 7 -> stuck_o=1 after the second capture. A capture of 32'h0 on a fresh reset also sets stuck_o; it stays 1 until reset=0.
6. Assert reset=0 with count_o=3 and drop_cnt_o=5 -> asynchronously valid_o=0, count_o=0, drop_cnt_o=0, stuck_o=0, without waiting for a clk edge.
